// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, counter sizing and default timing for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, DELAY, DONE, ERR} state_t;
  localparam int HOLD_CYC_DEF = 4;
  localparam int TO_CYC_DEF = 255;
  function automatic int cnt_w(input int dly_w, input int to_cyc, input int hold_cyc);
    int w;
    w = dly_w;
    if ($clog2(to_cyc + 1) > w) w = $clog2(to_cyc + 1);
    if ($clog2(hold_cyc + 1) > w) w = $clog2(hold_cyc + 1);
    return w;
  endfunction
endpackage

// File: rtl/ack_sync_bus.sv
// ack_sync_bus: multi-stage flop synchronizer bringing the domain acknowledges into Sync_clk
module ack_sync_bus #(
  parameter int N = 3,
  parameter int STAGES = 2
) (
  input  logic         Sync_clk,
  input  logic         Reg_reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [N-1:0] stg [STAGES];
  // shift the raw acknowledges through the synchronizer chain
  always_ff @(posedge Sync_clk or negedge Reg_reset) begin
    if (!Reg_reset) begin
      for (int s = 0; s < STAGES; s++) stg[s] <= '0;
    end else begin
      stg[0] <= d;
      for (int s = 1; s < STAGES; s++) stg[s] <= stg[s-1];
    end
  end
  assign q = stg[STAGES-1];
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases per-domain resets in index order, waiting for each acknowledge plus a programmable delay
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int DLY_W = 8,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int TO_CYC = TO_CYC_DEF,
  parameter int ACK_STAGES = 2
) (
  input  logic                           Sync_clk,
  input  logic                           Reg_reset,
  input  logic                           Scan_mode,
  input  logic                           soft_rst_req,
  input  logic [NUM_DOMAINS*DLY_W-1:0]   dly_cfg,
  input  logic [NUM_DOMAINS-1:0]         dom_ack,
  output logic [NUM_DOMAINS-1:0]         dom_rst_n,
  output logic                           sys_ready,
  output logic                           seq_busy,
  output logic                           err_flag,
  output logic [$clog2(NUM_DOMAINS)-1:0] err_dom
);
  localparam int CW = cnt_w(DLY_W, TO_CYC, HOLD_CYC);
  localparam int IW = $clog2(NUM_DOMAINS);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [IW-1:0] idx, idx_nxt, err_dom_q, err_dom_nxt, lost;
  logic [NUM_DOMAINS-1:0] dom_q, dom_nxt, ack_s;
  logic [DLY_W-1:0] dly;
  logic last;
  ack_sync_bus #(.N(NUM_DOMAINS), .STAGES(ACK_STAGES)) u_sync (
    .Sync_clk (Sync_clk),
    .Reg_reset(Reg_reset),
    .d        (dom_ack),
    .q        (ack_s)
  );
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign dly = dly_cfg[idx*DLY_W +: DLY_W];
  assign last = idx == IW'(NUM_DOMAINS - 1);
  // lowest-index domain whose acknowledge has dropped
  always_comb begin
    lost = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) if (!ack_s[i]) lost = IW'(i);
  end
  // next-state logic; soft reset overrides every other event on the same edge
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt_inc;
    idx_nxt = idx;
    err_dom_nxt = err_dom_q;
    dom_nxt = dom_q;
    if (soft_rst_req) begin
      state_nxt = HOLD;
      cnt_nxt = '0;
      idx_nxt = '0;
      err_dom_nxt = '0;
      dom_nxt = '0;
    end else begin
      case (state)
        HOLD: begin
          dom_nxt = '0;
          if (cnt >= CW'(HOLD_CYC)) begin
            state_nxt = RELEASE;
            idx_nxt = '0;
          end
        end
        RELEASE: begin
          dom_nxt = dom_q | (NUM_DOMAINS'(1) << idx);
          cnt_nxt = '0;
          state_nxt = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_s[idx]) begin
            cnt_nxt = '0;
            state_nxt = dly != '0 ? DELAY : last ? DONE : RELEASE;
            idx_nxt = (dly == '0 && !last) ? IW'(idx + 1'b1) : idx;
          end else if (cnt == CW'(TO_CYC - 1)) begin
            state_nxt = ERR;
            err_dom_nxt = idx;
          end
        end
        DELAY: begin
          if (cnt == CW'(dly) - CW'(1)) begin
            state_nxt = last ? DONE : RELEASE;
            idx_nxt = last ? idx : IW'(idx + 1'b1);
          end
        end
        DONE: begin
          if (!(&ack_s)) begin
            state_nxt = ERR;
            err_dom_nxt = lost;
          end
        end
        ERR: ;
        default: state_nxt = HOLD;
      endcase
    end
  end
  // sequencer state, counter, index and registered reset outputs
  always_ff @(posedge Sync_clk or negedge Reg_reset) begin
    if (!Reg_reset) begin
      state <= HOLD;
      cnt <= '0;
      idx <= '0;
      err_dom_q <= '0;
      dom_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      err_dom_q <= err_dom_nxt;
      dom_q <= dom_nxt;
    end
  end
  assign dom_rst_n = Scan_mode ? {NUM_DOMAINS{Reg_reset}} : dom_q;
  assign sys_ready = state == DONE;
  assign seq_busy = state != DONE && state != ERR;
  assign err_flag = state == ERR;
  assign err_dom = err_dom_q;
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset release sequencer for the multi-clock system: it drives the asynchronous reset inputs of the per-domain reset synchronizers and releases them one domain at a time, in index order. It waits for each domain's synchronized reset to come back high, then applies a programmable inter-domain delay before releasing the next domain. It raises `sys_ready` once every domain is out of reset and supports a register-driven soft reset. It sits in the always-on reference clock domain next to the SPI register file.

## Interface
- `NUM_DOMAINS`, 3: number of sequenced reset domains; domain 0 is released first.
- `DLY_W`, 8: width of each per-domain delay field.
- `HOLD_CYC`, 4: cycles all domains stay in reset after `Reg_reset` or soft reset before the sequence starts; must be ≥1.
- `TO_CYC`, 255: acknowledge timeout in `Sync_clk` cycles.
- `ACK_STAGES`, 2: synchronizer depth on acknowledge inputs.

Ports:
- `Sync_clk` in 1: sequencer clock.
- `Reg_reset` in 1: reset, asynchronous, active-low.
- `Scan_mode` in 1: test mode; bypasses the sequencer on the reset outputs.
- `soft_rst_req` in 1: single-cycle pulse requesting a full re-sequence.
- `dly_cfg` in `NUM_DOMAINS*DLY_W`: field i is the delay after domain i acknowledges; static while `seq_busy`=1.
- `dom_ack` in `NUM_DOMAINS`: per-domain synchronized-reset feedback; asynchronous to `Sync_clk`.
- `dom_rst_n` out `NUM_DOMAINS`: active-low resets to the domain synchronizers.
- `sys_ready` out 1: all domains released and acknowledged.
- `seq_busy` out 1: a sequence is in progress.
- `err_flag` out 1: sticky error flag.
- `err_dom` out `$clog2(NUM_DOMAINS)`: index of the failing domain.

## Operation
- FSM states are HOLD, RELEASE, WAIT_ACK, DELAY, DONE and ERR. The domain index `idx` is a register.
- **HOLD:** all `dom_rst_n`=0. A counter runs 0..`HOLD_CYC`-1, then goes to RELEASE with `idx`=0.
- **RELEASE:** sets `dom_rst_n[idx]`=1, clears the counter, then goes to WAIT_ACK.
- **WAIT_ACK:**
  - If `ack_s[idx]`=1, the state machine goes to DELAY. `ack_s` is the synchronized `dom_ack`.
  - If instead the counter reaches `TO_CYC`-1, it goes to ERR with `err_dom`=`idx`.
- **DELAY:** counts `dly_cfg[idx]` cycles. A value of 0 skips DELAY and leaves straight from WAIT_ACK.
  - If `idx`=`NUM_DOMAINS`-1, the next state is DONE.
  - Otherwise `idx` increments and the next state is RELEASE.
- **DONE:** `sys_ready`=1 and `seq_busy`=0. If any `ack_s` drops to 0, the state machine goes to ERR with `err_dom` set to the lowest such index.
- **ERR:** `err_flag`=1 and `sys_ready`=0. Already-released `dom_rst_n` bits keep their values. Only `soft_rst_req` or `Reg_reset` leaves ERR.
- **Soft reset:** `soft_rst_req`=1 in any state forces `dom_rst_n`=0 and `sys_ready`=0 at the next edge, clears `err_flag`, `err_dom` and `idx`, and enters HOLD. This also applies mid-sequence and in ERR.
- **Scan mode:** with `Scan_mode`=1, `dom_rst_n` = {`NUM_DOMAINS`{`Reg_reset`}} combinationally, and the FSM keeps running internally. With `Scan_mode`=0, `dom_rst_n` is the registered FSM value.
- All counters saturate and never wrap. Counter width is max(`DLY_W`, `$clog2(TO_CYC+1)`, `$clog2(HOLD_CYC+1)`).

## Timing
- **Reset values:** while `Reg_reset`=0:
  - `dom_rst_n`=0, `sys_ready`=0, `seq_busy`=1, `err_flag`=0, `err_dom`=0.
  - State HOLD, all counters 0, all `ack_s` stages 0.
- **First release:** counting the first rising edge after `Reg_reset` deasserts as edge 1, `dom_rst_n[0]` rises on edge `HOLD_CYC`+2.
- **Acknowledge latency:** `dom_ack[i]` rising is visible in `ack_s` after `ACK_STAGES` edges. DELAY or the next state is entered on the edge after that.
- **Next release:** with `dly_cfg[i]`=D>0, `dom_rst_n[i+1]` rises D+2 edges after `ack_s[i]` is first seen high. With D=0 it rises 2 edges after.
- **Ready:** `sys_ready` rises on the edge after the last DELAY completes.
- **Timeout:** ERR is entered exactly `TO_CYC` edges after WAIT_ACK entry if no acknowledge arrives.
- **Simultaneous events:** a soft reset and a timeout or ack loss on the same edge resolve as soft reset (HOLD, `err_flag`=0).

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum (HOLD, RELEASE, WAIT_ACK, DELAY, DONE, ERR);
  - the counter-width function;
  - the default `HOLD_CYC` and `TO_CYC` constants.
- Sub-module `ack_sync_bus`: a `NUM_DOMAINS`-wide, `ACK_STAGES`-deep flop synchronizer, cleared by `Reg_reset`, clocked by `Sync_clk`.

## Test plan
- **Nominal sequence:** `NUM_DOMAINS`=3, `dly_cfg`={8'd2,8'd0,8'd5}, each `dom_ack[i]` tied to `dom_rst_n[i]` delayed 2 edges -> releases on the exact edges given in Timing; `sys_ready`=1, `err_flag`=0.
- **Timeout:** `dom_ack[1]` held at 0 -> ERR after 255 cycles; `err_flag`=1, `err_dom`=1, `dom_rst_n`=3'b011.
- **Soft reset mid-sequence:** pulse `soft_rst_req` during DELAY of domain 0 -> `dom_rst_n`=0 next edge, then full re-sequence from HOLD.
- **Ack loss in DONE:** drop `dom_ack[2]` -> `sys_ready`=0 and `err_dom`=2 after `ACK_STAGES`+1 edges. A following soft reset recovers the system to `sys_ready`=1.
- **Scan and async reset:** `Scan_mode`=1 with `Reg_reset` toggled -> `dom_rst_n` follows `Reg_reset` combinationally. `Reg_reset` asserted while in DONE -> all outputs take their reset values immediately, without waiting for a clock edge.
